// File: rtl/tpu_command_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// tpu_command_scheduler_pkg : shared TPU opcodes, command width, FSM states
// Revision: 1.0
// ============================================================================
package tpu_command_scheduler_pkg;

  localparam int CMD_WIDTH = 48;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam logic [7:0] TPU_CLEARSCREEN = 8'h00;
  localparam logic [7:0] TPU_PRINT       = 8'h01;
  localparam logic [7:0] TPU_LOCATE      = 8'h02;
  localparam logic [7:0] TPU_SETATTR     = 8'h03;
  localparam logic [7:0] TPU_SETMASK     = 8'h04;
  localparam logic [7:0] TPU_FILLAREA    = 8'h05;

  typedef enum logic [1:0] {
    SEQ_IDLE       = 2'd0,
    SEQ_ISSUE      = 2'd1,
    SEQ_WAIT_START = 2'd2,
    SEQ_WAIT_DONE  = 2'd3
  } seq_state_t;

  function automatic logic [7:0] cmd_opcode(input logic [CMD_WIDTH-1:0] cmd);
    return cmd[7:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/tpu_command_scheduler_if.sv
`default_nettype none
// ============================================================================
// tpu_command_scheduler_if : source strobes, TPU handshake and queue status
// Revision: 1.0
// ============================================================================
interface tpu_command_scheduler_if #(
  parameter int FIFO_DEPTH = 4
);
  import tpu_command_scheduler_pkg::*;

  logic                          a_execute;
  logic [CMD_WIDTH-1:0]          a_command;
  logic                          a_busy;
  logic                          b_execute;
  logic [CMD_WIDTH-1:0]          b_command;
  logic                          b_busy;
  logic                          tpu_busy;
  logic                          tpu_execute;
  logic [CMD_WIDTH-1:0]          tpu_command;
  logic [$clog2(FIFO_DEPTH):0]   pending;

  modport slave (
    input  a_execute, a_command, b_execute, b_command, tpu_busy,
    output a_busy, b_busy, tpu_execute, tpu_command, pending
  );

  modport master (
    output a_execute, a_command, b_execute, b_command, tpu_busy,
    input  a_busy, b_busy, tpu_execute, tpu_command, pending
  );

endinterface
`default_nettype wire

// File: rtl/tpu_command_scheduler_cmd_fifo.sv
`default_nettype none
// ============================================================================
// cmd_fifo : synchronous FIFO with occupancy count, power-of-two depth
// Revision: 1.0
// ============================================================================
module cmd_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          pop_data,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_do_push = push & ~full;
  assign w_do_pop  = pop & ~empty;

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/tpu_command_scheduler.sv
`default_nettype none
// ============================================================================
// tpu_command_scheduler : two-source holding regs, round-robin into a FIFO,
// one-at-a-time TPU issue sequencer.  Revision: 1.0
// ============================================================================
module tpu_command_scheduler
  import tpu_command_scheduler_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int START_TIMEOUT = 15
) (
  input  logic                    clk,
  input  logic                    reset,
  tpu_command_scheduler_if.slave  bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int TW = $clog2(START_TIMEOUT + 2);

  logic                 r_a_valid, r_a_sent, r_b_valid, r_b_sent, r_favour_b;
  logic [CMD_WIDTH-1:0] r_a_cmd, r_b_cmd;
  logic                 w_a_elig, w_b_elig, w_grant_a, w_grant_b;
  logic                 w_push, w_pop, w_full, w_empty;
  logic [CMD_WIDTH-1:0] w_push_data, w_head;
  logic [CW-1:0]        w_count;

  seq_state_t           r_state, w_state_nxt;
  logic [TW-1:0]        r_timer, w_timer_nxt;
  logic                 r_tpu_execute;
  logic [CMD_WIDTH-1:0] r_tpu_command;

  // A transferred entry keeps its port busy for one more cycle ("sent").
  assign w_a_elig    = r_a_valid & ~r_a_sent;
  assign w_b_elig    = r_b_valid & ~r_b_sent;
  assign w_grant_a   = w_a_elig & ~w_full & (~w_b_elig | ~r_favour_b);
  assign w_grant_b   = w_b_elig & ~w_full & (~w_a_elig |  r_favour_b);
  assign w_push      = w_grant_a | w_grant_b;
  assign w_push_data = w_grant_a ? r_a_cmd : r_b_cmd;

  assign bus.a_busy      = r_a_valid;
  assign bus.b_busy      = r_b_valid;
  assign bus.tpu_execute = r_tpu_execute;
  assign bus.tpu_command = r_tpu_command;
  assign bus.pending     = w_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_valid  <= FALSE;
      r_a_sent   <= FALSE;
      r_a_cmd    <= '0;
      r_b_valid  <= FALSE;
      r_b_sent   <= FALSE;
      r_b_cmd    <= '0;
      r_favour_b <= FALSE;
    end else begin
      if (!r_a_valid) begin
        if (bus.a_execute) begin
          r_a_valid <= TRUE;
          r_a_cmd   <= bus.a_command;
        end
      end else if (r_a_sent) begin
        r_a_valid <= FALSE;
        r_a_sent  <= FALSE;
      end else if (w_grant_a) begin
        r_a_sent  <= TRUE;
      end

      if (!r_b_valid) begin
        if (bus.b_execute) begin
          r_b_valid <= TRUE;
          r_b_cmd   <= bus.b_command;
        end
      end else if (r_b_sent) begin
        r_b_valid <= FALSE;
        r_b_sent  <= FALSE;
      end else if (w_grant_b) begin
        r_b_sent  <= TRUE;
      end

      // The pointer only moves when both ports actually contended.
      if (w_a_elig && w_b_elig && !w_full) r_favour_b <= ~r_favour_b;
    end
  end

  cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .pop_data  (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= SEQ_IDLE;
      r_timer       <= '0;
      r_tpu_execute <= FALSE;
      r_tpu_command <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_timer       <= w_timer_nxt;
      r_tpu_execute <= w_pop;
      if (w_pop) r_tpu_command <= w_head;
    end
  end

  // The pop happens on the edge into ISSUE, so the strobe is high during ISSUE.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_pop       = FALSE;
    case (r_state)
      SEQ_IDLE: begin
        if (!w_empty && !bus.tpu_busy) begin
          w_state_nxt = SEQ_ISSUE;
          w_pop       = TRUE;
        end
      end
      SEQ_ISSUE: begin
        w_state_nxt = SEQ_WAIT_START;
        w_timer_nxt = TW'(START_TIMEOUT);
      end
      SEQ_WAIT_START: begin
        if (bus.tpu_busy) begin
          w_state_nxt = SEQ_WAIT_DONE;
        end else if (r_timer <= TW'(1)) begin
          w_state_nxt = SEQ_IDLE;
        end else begin
          w_timer_nxt = r_timer - TW'(1);
        end
      end
      SEQ_WAIT_DONE: begin
        if (!bus.tpu_busy) w_state_nxt = SEQ_IDLE;
      end
      default: w_state_nxt = SEQ_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_tpu_command_scheduler.sv
`default_nettype none
// ============================================================================
// tb_tpu_command_scheduler : directed + random stimulus against a queue model
// Revision: 1.0
// ============================================================================
module tb_tpu_command_scheduler;
  import tpu_command_scheduler_pkg::*;

  localparam int FIFO_DEPTH    = 4;
  localparam int START_TIMEOUT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tpu_command_scheduler_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus();

  tpu_command_scheduler #(
    .FIFO_DEPTH    (FIFO_DEPTH),
    .START_TIMEOUT (START_TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic force_busy = 1'b0;
  logic auto_busy  = 1'b0;
  assign bus.tpu_busy = force_busy | auto_busy;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, expected condition never met (t=%0t)", name, $time);
  endtask

  // ---------------- reference model: queue FIFO, holding slots, deadlines ----
  logic [47:0] fifo_q[$];
  bit          ma_full, ma_done, mb_full, mb_done, m_pref_b;
  logic [47:0] ma_cmd, mb_cmd;
  bit          m_seq_busy, m_seen;
  int          m_k;
  bit          e_exec;
  logic [47:0] e_cmd;

  initial forever begin
    @(posedge clk or posedge reset);
    if (reset) begin
      fifo_q.delete();
      ma_full = 0; ma_done = 0; mb_full = 0; mb_done = 0; m_pref_b = 0;
      ma_cmd = '0; mb_cmd = '0;
      m_seq_busy = 0; m_seen = 0; m_k = 0;
      e_exec = 0; e_cmd = '0;
    end else begin
      bit full, ea, eb, ga, gb, pop, rel_a, rel_b, cap_a, cap_b;
      full = (fifo_q.size() == FIFO_DEPTH);
      ea = ma_full && !ma_done;
      eb = mb_full && !mb_done;
      ga = 0; gb = 0;
      if (!full) begin
        if (ea && eb) begin
          if (m_pref_b) gb = 1; else ga = 1;
          m_pref_b = !m_pref_b;
        end else if (ea) ga = 1;
        else if (eb) gb = 1;
      end
      pop = !m_seq_busy && fifo_q.size() > 0 && !bus.tpu_busy;
      if (m_seq_busy) begin
        // m_k counts cycles since the pulse cycle; busy is ignored during the pulse.
        if (m_k > 0) begin
          if (!m_seen) begin
            if (bus.tpu_busy) m_seen = 1;
            else if (m_k >= START_TIMEOUT) m_seq_busy = 0;
          end else if (!bus.tpu_busy) begin
            m_seq_busy = 0;
            m_seen = 0;
          end
        end
        m_k++;
      end
      e_exec = pop;
      if (pop) begin
        e_cmd = fifo_q.pop_front();
        m_seq_busy = 1;
        m_seen = 0;
        m_k = 0;
      end
      if (ga) fifo_q.push_back(ma_cmd);
      if (gb) fifo_q.push_back(mb_cmd);
      rel_a = ma_full && ma_done;
      rel_b = mb_full && mb_done;
      cap_a = !ma_full && bus.a_execute;
      cap_b = !mb_full && bus.b_execute;
      if (rel_a) begin ma_full = 0; ma_done = 0; end
      if (rel_b) begin mb_full = 0; mb_done = 0; end
      if (ga) ma_done = 1;
      if (gb) mb_done = 1;
      if (cap_a) begin ma_full = 1; ma_done = 0; ma_cmd = bus.a_command; end
      if (cap_b) begin mb_full = 1; mb_done = 0; mb_cmd = bus.b_command; end
    end
  end

  // ---------------- monitor: per-cycle compare, logging, TPU responder -------
  int          cyc = 0;
  int          busy_len = 0;
  int          b_from = 1, b_to = 0;
  logic [47:0] issued[$];
  int          issue_cyc[$];
  int          a_hi = 0, b_hi = 0, pend_max = 0, pend_one = 0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (reset) begin
      auto_busy = 1'b0;
      b_from = 1;
      b_to   = 0;
    end else begin
      chk("a_busy",      64'(bus.a_busy),      64'(ma_full));
      chk("b_busy",      64'(bus.b_busy),      64'(mb_full));
      chk("tpu_execute", 64'(bus.tpu_execute), 64'(e_exec));
      chk("tpu_command", 64'(bus.tpu_command), 64'(e_cmd));
      chk("pending",     64'(bus.pending),     64'(fifo_q.size()));
      if (bus.tpu_execute === 1'b1) begin
        chk("exec_while_tpu_busy", 64'(bus.tpu_busy), 64'd0);
        issued.push_back(bus.tpu_command);
        issue_cyc.push_back(cyc);
        if (busy_len > 0) begin
          b_from = cyc + 2;
          b_to   = cyc + 1 + busy_len;
        end
      end
      a_hi += int'(bus.a_busy);
      b_hi += int'(bus.b_busy);
      if (int'(bus.pending) > pend_max) pend_max = int'(bus.pending);
      if (bus.pending == 1) pend_one++;
      auto_busy = (cyc >= b_from && cyc <= b_to);
    end
  end

  // ---------------- stimulus helpers ----------------------------------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_logs();
    issued.delete();
    issue_cyc.delete();
    a_hi = 0; b_hi = 0; pend_max = 0; pend_one = 0;
  endtask

  function automatic logic [47:0] iss(input int i);
    if (i < issued.size()) return issued[i];
    return 48'hFFFF_FFFF_FFFF;
  endfunction

  task automatic do_strobe(input bit pb, input logic [47:0] cmd);
    if (pb) begin bus.b_execute = 1'b1; bus.b_command = cmd; end
    else    begin bus.a_execute = 1'b1; bus.a_command = cmd; end
    tick();
    bus.a_execute = 1'b0;
    bus.b_execute = 1'b0;
  endtask

  task automatic strobe_ab(input logic [47:0] ca, input logic [47:0] cb);
    bus.a_execute = 1'b1; bus.a_command = ca;
    bus.b_execute = 1'b1; bus.b_command = cb;
    tick();
    bus.a_execute = 1'b0;
    bus.b_execute = 1'b0;
  endtask

  task automatic wait_free(input bit pb);
    int n = 0;
    while ((pb ? bus.b_busy : bus.a_busy) && n < 100) begin tick(); n++; end
    if (n >= 100) fail_timeout("wait_free");
  endtask

  task automatic drain();
    int n = 0;
    while ((bus.pending != 0 || bus.a_busy || bus.b_busy) && n < 800) begin tick(); n++; end
    if (n >= 800) fail_timeout("drain");
    repeat (45) tick();
  endtask

  // ---------------- main sequence --------------------------------------------
  initial begin
    logic [63:0] rnd;
    logic [47:0] exp_q[$];
    int          n;

    bus.a_execute = 1'b0; bus.a_command = '0;
    bus.b_execute = 1'b0; bus.b_command = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_a_busy",      64'(bus.a_busy),      64'd0);
    chk("rst_b_busy",      64'(bus.b_busy),      64'd0);
    chk("rst_tpu_execute", 64'(bus.tpu_execute), 64'd0);
    chk("rst_tpu_command", 64'(bus.tpu_command), 64'd0);
    chk("rst_pending",     64'(bus.pending),     64'd0);
    repeat (2) tick();

    // Single command with a 5-cycle busy pulse two cycles after issue.
    busy_len = 5;
    clear_logs();
    do_strobe(0, 48'h0000_0000_4101);
    drain();
    chk("single_count",    64'(issued.size()), 64'd1);
    chk("single_cmd",      64'(iss(0)),        64'h0000_0000_4101);
    chk("single_a_busy",   64'(a_hi),          64'd2);
    chk("single_pend_max", 64'(pend_max),      64'd1);
    chk("single_pend_one", 64'(pend_one),      64'd1);

    // Simultaneous strobes: A wins first, the second pair goes to B.
    clear_logs();
    strobe_ab(48'h0000_0000_0A03, 48'h0000_0000_0B03);
    drain();
    chk("sim1_first",  64'(iss(0)), 64'h0A03);
    chk("sim1_second", 64'(iss(1)), 64'h0B03);
    chk("sim1_a_busy", 64'(a_hi),   64'd2);
    chk("sim1_b_busy", 64'(b_hi),   64'd3);
    clear_logs();
    strobe_ab(48'h0000_0000_0C03, 48'h0000_0000_0D03);
    drain();
    chk("sim2_first",  64'(iss(0)), 64'h0D03);
    chk("sim2_second", 64'(iss(1)), 64'h0C03);
    chk("sim2_b_busy", 64'(b_hi),   64'd2);
    chk("sim2_a_busy", 64'(a_hi),   64'd3);

    // Backpressure with the TPU held busy.
    force_busy = 1'b1;
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      wait_free(0);
      do_strobe(0, 48'h1000 + 48'(i));
    end
    chk("bp_busy_before_6th", 64'(bus.a_busy), 64'd1);
    do_strobe(0, 48'h0000_0000_DEAD);
    repeat (6) tick();
    chk("bp_pend_max", 64'(pend_max),    64'd4);
    chk("bp_pending",  64'(bus.pending), 64'd4);
    chk("bp_a_busy",   64'(bus.a_busy),  64'd1);
    chk("bp_no_issue", 64'(issued.size()), 64'd0);
    force_busy = 1'b0;
    busy_len = 2;
    drain();
    chk("bp_count", 64'(issued.size()), 64'd5);
    for (int i = 0; i < 5; i++) chk("bp_order", 64'(iss(i)), 64'h1000 + 64'(i));

    // TPU that never raises busy: issues spaced by the start timeout.
    busy_len = 0;
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      wait_free(0);
      do_strobe(0, 48'h2000 + 48'(i));
    end
    drain();
    chk("fast_count", 64'(issued.size()), 64'd3);
    if (issue_cyc.size() == 3) begin
      chk("fast_gap1", 64'(issue_cyc[1] - issue_cyc[0]), 64'(START_TIMEOUT + 2));
      chk("fast_gap2", 64'(issue_cyc[2] - issue_cyc[1]), 64'(START_TIMEOUT + 2));
    end
    chk("fast_last", 64'(iss(2)), 64'h2002);

    // Reset while the TPU is busy and three commands are queued.
    busy_len = 30;
    clear_logs();
    do_strobe(0, 48'h3000);
    wait_free(0);
    do_strobe(0, 48'h3001);
    wait_free(1);
    do_strobe(1, 48'h3002);
    wait_free(0);
    do_strobe(0, 48'h3003);
    n = 0;
    while (bus.pending != 3 && n < 60) begin tick(); n++; end
    if (n >= 60) fail_timeout("rst_wait_pending3");
    #1 reset = 1'b1;
    #1;
    chk("arst_a_busy",      64'(bus.a_busy),      64'd0);
    chk("arst_b_busy",      64'(bus.b_busy),      64'd0);
    chk("arst_tpu_execute", 64'(bus.tpu_execute), 64'd0);
    chk("arst_tpu_command", 64'(bus.tpu_command), 64'd0);
    chk("arst_pending",     64'(bus.pending),     64'd0);
    repeat (2) tick();
    reset = 1'b0;
    clear_logs();
    repeat (50) tick();
    chk("arst_no_issue", 64'(issued.size()), 64'd0);
    chk("arst_idle_pending", 64'(bus.pending), 64'd0);

    // Wrap-around: 20 alternating commands, one holding slot in use at a time.
    busy_len = 3;
    clear_logs();
    exp_q.delete();
    for (int i = 0; i < 20; i++) begin
      rnd = {$urandom(), $urandom()};
      wait_free(0);
      wait_free(1);
      do_strobe(i[0], rnd[47:0]);
      exp_q.push_back(rnd[47:0]);
      repeat ($urandom_range(0, 3)) tick();
    end
    drain();
    chk("wrap_count", 64'(issued.size()), 64'd20);
    for (int i = 0; i < 20; i++) chk("wrap_order", 64'(iss(i)), 64'(exp_q[i]));

    // Random strobes on both ports, legal and illegal, varying TPU behaviour.
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) busy_len = $urandom_range(0, 4);
      rnd = {$urandom(), $urandom()};
      bus.a_execute = ($urandom_range(0, 2) == 0);
      bus.a_command = rnd[47:0];
      rnd = {$urandom(), $urandom()};
      bus.b_execute = ($urandom_range(0, 2) == 0);
      bus.b_command = rnd[47:0];
      tick();
    end
    bus.a_execute = 1'b0;
    bus.b_execute = 1'b0;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
